// File: rtl/pio_edge_in_pkg.sv
// Shared register map, bus payload type and CONFIG word layout for pio_edge_in.
package pio_edge_in_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_RISE_EN  = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_FALL_EN  = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_IRQ_MODE = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_CONFIG   = 3'd7;

  localparam int unsigned CFG_FIELD_W   = 8;
  localparam int unsigned CFG_WIDTH_LSB = 0;
  localparam int unsigned CFG_SYNC_LSB  = 8;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  // CONFIG word: {16'h0, sync_stages[7:0], width[7:0]}
  function automatic logic [DATA_W-1:0] config_word(input int unsigned width,
                                                    input int unsigned sync_stages);
    logic [DATA_W-1:0] w;
    w = '0;
    w[CFG_WIDTH_LSB +: CFG_FIELD_W] = CFG_FIELD_W'(width);
    w[CFG_SYNC_LSB  +: CFG_FIELD_W] = CFG_FIELD_W'(sync_stages);
    return w;
  endfunction

endpackage

// File: rtl/pio_edge_in_filter.sv
// Per-bit input conditioner: synchroniser chain plus optional debounce
// (enabled by defining PIO_EDGE_IN_DEBOUNCE_EN).
module pio_edge_in_filter #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("pio_edge_in_filter: SYNC_STAGES must be 2..4");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("pio_edge_in_filter: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

`ifdef PIO_EDGE_IN_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             s_c;
  logic             filt_q;
  logic [CNT_W-1:0] cnt_q;

  assign s_c = sync_q[SYNC_STAGES-1];

  // Output only follows s after it has disagreed for DEBOUNCE_CYCLES counts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else if (s_c == filt_q) begin
      cnt_q  <= '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
      filt_q <= s_c;
      cnt_q  <= '0;
    end else begin
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

  assign dout = filt_q;
`else
  assign dout = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/pio_edge_in.sv
// Avalon-MM input PIO with per-bit rise/fall edge capture, W1C clear and
// level/edge IRQ. Optional input debounce via PIO_EDGE_IN_DEBOUNCE_EN.
module pio_edge_in
  import pio_edge_in_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [DATA_W-1:0] readdata,
  output logic              irq
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("pio_edge_in: WIDTH must be 1..32");
  end

  logic [WIDTH-1:0]  filt;
  logic [WIDTH-1:0]  prev_q;
  logic [WIDTH-1:0]  rise_en_q;
  logic [WIDTH-1:0]  irq_mask_q;
  logic [WIDTH-1:0]  fall_en_q;
  logic [WIDTH-1:0]  edge_cap_q;
  logic              irq_mode_q;

  wr_req_t           wr_c;
  logic [WIDTH-1:0]  wr_bits_c;
  logic [WIDTH-1:0]  rise_c;
  logic [WIDTH-1:0]  fall_c;
  logic [WIDTH-1:0]  edge_hit_c;
  logic [WIDTH-1:0]  clr_c;
  logic [DATA_W-1:0] rd_mux_c;
  logic              unused_wdata_c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_edge_in_filter #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_filter (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (in_port[i]),
      .dout    (filt[i])
    );
  end

  always_comb begin
    wr_c.en   = chipselect & ~write_n;
    wr_c.addr = address;
    wr_c.data = writedata;
  end

  assign wr_bits_c      = wr_c.data[WIDTH-1:0];
  assign unused_wdata_c = ^wr_c.data;

  // Edge detection and W1C clear mask
  always_comb begin
    rise_c     = filt & ~prev_q;
    fall_c     = ~filt & prev_q;
    edge_hit_c = (rise_c & rise_en_q) | (fall_c & fall_en_q);
    clr_c      = '0;
    if (wr_c.en && wr_c.addr == ADDR_EDGE_CAP) clr_c = wr_bits_c;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q     <= '0;
      edge_cap_q <= '0;
    end else begin
      prev_q     <= filt;
      // A new edge overrides a same-cycle clear so no event is lost
      edge_cap_q <= edge_hit_c | (edge_cap_q & ~clr_c);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_en_q  <= '1;
      irq_mask_q <= '0;
      fall_en_q  <= '0;
      irq_mode_q <= 1'b0;
    end else if (wr_c.en) begin
      case (wr_c.addr)
        ADDR_RISE_EN:  rise_en_q  <= wr_bits_c;
        ADDR_IRQ_MASK: irq_mask_q <= wr_bits_c;
        ADDR_FALL_EN:  fall_en_q  <= wr_bits_c;
        ADDR_IRQ_MODE: irq_mode_q <= wr_c.data[0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_mux_c = '0;
    case (address)
      ADDR_DATA:     rd_mux_c = DATA_W'(filt);
      ADDR_RISE_EN:  rd_mux_c = DATA_W'(rise_en_q);
      ADDR_IRQ_MASK: rd_mux_c = DATA_W'(irq_mask_q);
      ADDR_EDGE_CAP: rd_mux_c = DATA_W'(edge_cap_q);
      ADDR_FALL_EN:  rd_mux_c = DATA_W'(fall_en_q);
      ADDR_IRQ_MODE: rd_mux_c = DATA_W'(irq_mode_q);
      ADDR_CONFIG:   rd_mux_c = config_word(WIDTH, SYNC_STAGES);
      default:       rd_mux_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux_c;
  end

  assign irq = irq_mode_q ? |(edge_cap_q & irq_mask_q) : |(filt & irq_mask_q);

endmodule
